// File: rtl/multicycle_control_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : multicycle_control_if
// Shared instruction/data memory handshake between controller and memory.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface multicycle_control_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ack;

  modport master (
    output mem_read,
    output mem_write,
    output iord,
    input  mem_ack
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  iord,
    output mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : multicycle_control
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit processor.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module multicycle_control #(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  multicycle_control_if.master mem,
  input  logic [OPCODE_W-1:0]  opcode_i,
  input  logic                 zero_i,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic [1:0]           alu_op_o,
  output logic                 reg_dst_o,
  output logic                 mem_to_reg_o,
  output logic                 alu_src_o,
  output logic                 jump_o,
  output logic                 branch_o,
  output logic                 reg_write_o,
  output logic                 link_o,
  output logic                 retire_o,
  output logic                 illegal_o,
  output logic                 bus_error_o,
  output logic [CNT_W-1:0]     retired_count_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_SHL  = 2'b10;
  localparam logic [1:0] ALU_ADDI = 2'b11;

  localparam int                WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT > 0);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WAIT_W-1:0]   wait_inc;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2:0]          op_lo;
  logic                op_hi_set;
  logic                timeout;
  logic                mem_read_c;
  logic                mem_write_c;
  logic                iord_c;

  assign op_lo = opcode_q[2:0];

  // Any set bit above the 3-bit opcode makes the instruction illegal.
  generate
    if (OPCODE_W > 3) begin : g_op_hi
      assign op_hi_set = |opcode_q[OPCODE_W-1:3];
    end else begin : g_op_no_hi
      assign op_hi_set = 1'b0;
    end
  endgenerate

  // Saturating so a disabled timeout never wraps into a false limit hit.
  assign wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
  assign timeout  = TIMEOUT_EN && (wait_q == WAIT_MAX) && !mem.mem_ack;

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    iord_c       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    alu_op_o     = ALU_ADD;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_o    = 1'b0;
    jump_o       = 1'b0;
    branch_o     = 1'b0;
    reg_write_o  = 1'b0;
    link_o       = 1'b0;
    retire_o     = 1'b0;
    illegal_o    = 1'b0;
    bus_error_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem.mem_ack) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          bus_error_o = 1'b1;
          state_d     = S_FETCH;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_DECODE: begin
        if (op_hi_set) begin
          illegal_o = 1'b1;
          state_d   = S_FETCH;
        end else begin
          case (op_lo)
            OP_J: begin
              jump_o     = 1'b1;
              pc_write_o = 1'b1;
              retire_o   = 1'b1;
              state_d    = S_FETCH;
            end
            OP_JAL: begin
              jump_o      = 1'b1;
              pc_write_o  = 1'b1;
              reg_write_o = 1'b1;
              link_o      = 1'b1;
              retire_o    = 1'b1;
              state_d     = S_FETCH;
            end
            default: begin
              state_d = S_EXEC;
            end
          endcase
        end
      end

      S_EXEC: begin
        case (op_lo)
          OP_ADD: begin
            alu_op_o = ALU_ADD;
            state_d  = S_WB;
          end
          OP_SLI: begin
            alu_op_o  = ALU_SHL;
            alu_src_o = 1'b1;
            state_d   = S_WB;
          end
          OP_ADDI: begin
            alu_op_o  = ALU_ADDI;
            alu_src_o = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op_o  = ALU_ADDI;
            alu_src_o = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op_o   = ALU_SUB;
            branch_o   = 1'b1;
            pc_write_o = zero_i;
            retire_o   = 1'b1;
            state_d    = S_FETCH;
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        iord_c = 1'b1;
        if (op_lo == OP_SW) begin
          mem_write_c = 1'b1;
        end else begin
          mem_read_c = 1'b1;
        end
        if (mem.mem_ack) begin
          if (op_lo == OP_SW) begin
            retire_o = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          bus_error_o = 1'b1;
          state_d     = S_FETCH;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (op_lo == OP_ADD);
        mem_to_reg_o = (op_lo == OP_LW);
        retire_o     = 1'b1;
        state_d      = S_FETCH;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign opcode_d = ir_write_o ? opcode_i : opcode_q;
  assign count_d  = retire_o ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
    end
  end

  assign mem.mem_read    = mem_read_c;
  assign mem.mem_write   = mem_write_c;
  assign mem.iord        = iord_c;
  assign retired_count_o = count_q;
  assign state_o         = state_q;

endmodule
`default_nettype wire
